muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port: start  input  1  request a new operation; sampled on the rising clock edge.
REQ-004 SHALL have port: op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port: rs_val  input  32  first operand (multiplicand/dividend); also the HI/LO write data.
REQ-006 SHALL have port: rt_val  input  32  second operand (multiplier/divisor).
REQ-007 SHALL have port: hi_we  input  1  write rs_val into HI (MTHI).
REQ-008 SHALL have port: lo_we  input  1  write rs_val into LO (MTLO).
REQ-009 SHALL have port: hi  output  32  HI register (product upper word / remainder).
REQ-010 SHALL have port: lo  output  32  LO register (product lower word / quotient).
REQ-011 SHALL have port: busy  output  1  operation in progress; upstream pipeline register write-enable = ~busy.
REQ-012 SHALL have port: done  output  1  one-cycle pulse marking that the result is in HI/LO.
REQ-013 SHALL have port: div_by_zero  output  1  last accepted divide had a zero divisor.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV and DONE.
REQ-015 SHALL accept start only in IDLE or DONE; start in MUL/DIV is ignored, with no effect on the operation in flight.
REQ-016 SHALL, on an accepted start, latch op, rs_val and rt_val, clear div_by_zero, and go to MUL (op 0x) or DIV (op 1x).
REQ-017 SHALL run exactly 32 iteration cycles in MUL/DIV, one bit per cycle (shift-add multiply, restoring divide), then enter DONE.
REQ-018 SHALL write HI/LO on the edge entering DONE, so done is high in the 32nd cycle after the start-sampling edge.
REQ-019 SHALL hold busy high in MUL and DIV only, and low in IDLE and DONE.
REQ-020 SHALL assert done only in DONE; DONE goes to IDLE next edge, or straight to MUL/DIV if start is high (back-to-back issue).
REQ-021 SHALL, for signed ops, operate on magnitudes and fix signs at the end: product sign = XOR of operand signs; quotient sign = XOR; remainder sign = dividend sign.
REQ-022 SHALL produce a 64-bit product with {hi,lo} = full result; DIV/DIVU put quotient in lo and remainder in hi.
REQ-023 SHALL handle DIV 0x80000000 / 0xFFFFFFFF with lo=0x80000000, hi=0, no flag.
REQ-024 SHALL, on a zero divisor, skip iteration: go to DONE on the next edge with hi=rs_val, lo=0xFFFFFFFF, div_by_zero=1 (held until the next accepted start).
REQ-025 SHALL apply hi_we/lo_we only when busy is low; while busy they are ignored.
REQ-026 SHALL, if hi_we/lo_we and start coincide, perform the write and accept the start; the later result overwrites the write.
REQ-027 SHALL, if hi_we/lo_we occur in DONE, perform the write over the just-written result.

Reset
REQ-028 SHALL, while reset is high, force state=IDLE and hi=0, lo=0, busy=0, done=0, div_by_zero=0, asynchronously and regardless of clock.
REQ-029 SHALL discard an operation in flight when reset is asserted mid-operation; no done pulse follows.
REQ-030 SHALL, after reset deasserts, give the first accepted start the full latency.

Configuration
REQ-031 SHALL include the divide datapath only when macro MULDIV_DIVIDE_EN is defined; behaviour with the macro is as specified above.
REQ-032 SHALL, without MULDIV_DIVIDE_EN, complete op 10/11 via DONE on the next edge, with hi/lo unchanged and div_by_zero=0; MUL behaviour is identical with and without the macro.

Verification
REQ-033 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy for 32 cycles; done in cycle 32.
REQ-034 SHALL cover: MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-035 SHALL cover: DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/0 -> done next cycle, hi=0x64, lo=0xFFFFFFFF, div_by_zero=1.
REQ-036 SHALL cover: reset at iteration 10 -> hi=lo=0, busy=done=0 immediately; following MULTU 3x5 -> lo=15 after the full latency.
REQ-037 SHALL cover: start held during MUL -> ignored; start during DONE -> new op begins with no IDLE cycle; hi_we while busy -> hi unchanged.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers (shift-add multiply, restoring divide).
// Define MULDIV_DIVIDE_EN to include the divide datapath; without it DIV/DIVU complete immediately.
module muldiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] accHi_q, accHi_d;
    logic [31:0] accLo_q, accLo_d;
    logic [31:0] opB_q, opB_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        negRes_q, negRes_d;
    logic        negRem_q, negRem_d;
    logic        dbz_q, dbz_d;

    logic        rsNeg, rtNeg;
    logic [31:0] rsMag, rtMag;
    logic [32:0] mulSum;
    logic [31:0] mulHi, mulLo;
    logic [63:0] prodMag, prodFix;

    // Signed ops (op[0] == 0) work on magnitudes; signs are reapplied on the final step.
    assign rsNeg   = ~op[0] & rs_val[31];
    assign rtNeg   = ~op[0] & rt_val[31];
    assign rsMag   = rsNeg ? -rs_val : rs_val;
    assign rtMag   = rtNeg ? -rt_val : rt_val;

    assign mulSum  = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opB_q} : 33'd0);
    assign mulHi   = mulSum[32:1];
    assign mulLo   = {mulSum[0], accLo_q[31:1]};
    assign prodMag = {mulHi, mulLo};
    assign prodFix = negRes_q ? -prodMag : prodMag;

`ifdef MULDIV_DIVIDE_EN
    logic [33:0] divTrial;
    logic        divOk;
    logic [31:0] divRem, divQuo, remFix, quoFix, dvdFix;

    // 34 bits so the borrow stays unambiguous when the shifted remainder exceeds 2^32.
    assign divTrial = {1'b0, accHi_q, accLo_q[31]} - {2'b00, opB_q};
    assign divOk    = ~divTrial[33];
    assign divRem   = divOk ? divTrial[31:0] : {accHi_q[30:0], accLo_q[31]};
    assign divQuo   = {accLo_q[30:0], divOk};
    assign remFix   = negRem_q ? -divRem : divRem;
    assign quoFix   = negRes_q ? -divQuo : divQuo;
    assign dvdFix   = negRem_q ? -accLo_q : accLo_q;
`endif

    // State register and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            accHi_q  <= 32'd0;
            accLo_q  <= 32'd0;
            opB_q    <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            accHi_q  <= accHi_d;
            accLo_q  <= accLo_d;
            opB_q    <= opB_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            negRes_q <= negRes_d;
            negRem_q <= negRem_d;
            dbz_q    <= dbz_d;
        end
    end

    // Next-state logic: accept/MTHI/MTLO when idle or done, iterate one bit per cycle otherwise.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accHi_d  = accHi_q;
        accLo_d  = accLo_q;
        opB_d    = opB_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        negRes_d = negRes_q;
        negRem_d = negRem_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (hi_we) hi_d = rs_val;
                if (lo_we) lo_d = rs_val;
                state_d = IDLE;
                if (start) begin
                    cnt_d    = 5'd0;
                    dbz_d    = 1'b0;
                    accHi_d  = 32'd0;
                    negRes_d = rsNeg ^ rtNeg;
                    negRem_d = rsNeg;
                    if (op[1]) begin
                        state_d = DIV;
                        accLo_d = rsMag;
                        opB_d   = rtMag;
                    end else begin
                        state_d = MUL;
                        accLo_d = rtMag;
                        opB_d   = rsMag;
                    end
                end
            end
            MUL: begin
                accHi_d = mulHi;
                accLo_d = mulLo;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    hi_d    = prodFix[63:32];
                    lo_d    = prodFix[31:0];
                    state_d = DONE;
                end
            end
            DIV: begin
`ifdef MULDIV_DIVIDE_EN
                if (opB_q == 32'd0) begin
                    hi_d    = dvdFix;
                    lo_d    = '1;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    accHi_d = divRem;
                    accLo_d = divQuo;
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        hi_d    = remFix;
                        lo_d    = quoFix;
                        state_d = DONE;
                    end
                end
`else
                state_d = DONE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q == MUL) || (state_q == DIV);
    assign done        = (state_q == DONE);
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; divide expectations follow MULDIV_DIVIDE_EN.
module tb_muldiv_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;
    int lat;
    int bc;

    muldiv_unit dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .op(op),
        .rs_val(rs_val),
        .rt_val(rt_val),
        .hi_we(hi_we),
        .lo_we(lo_we),
        .hi(hi),
        .lo(lo),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Pulse start for one edge; returns half a cycle after the sampling edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(negedge clock);
        start  = 1'b0;
    endtask

    task automatic waitDone(output int l, output int busyCnt);
        l = 0;
        busyCnt = 0;
        while (!done && l < 100) begin
            if (busy) busyCnt++;
            @(negedge clock);
            l++;
        end
        if (!done) checkOutput("doneTimeout", 32'd0, 32'd1);
    endtask

    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int expLat, input int expBusy, input logic [31:0] expHi,
                         input logic [31:0] expLo, input logic expDbz);
        int l, bcnt;
        applyStimulus(o, a, b);
        waitDone(l, bcnt);
        checkOutput({tag, ".lat"}, l, expLat);
        checkOutput({tag, ".busy"}, bcnt, expBusy);
        checkOutput({tag, ".hi"}, hi, expHi);
        checkOutput({tag, ".lo"}, lo, expLo);
        checkOutput({tag, ".dbz"}, div_by_zero, expDbz);
        @(negedge clock);
        checkOutput({tag, ".donePulse"}, done, 1'b0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        rs_val = 32'd0;
        rt_val = 32'd0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        #1;
        checkOutput("rst.hi", hi, 32'd0);
        checkOutput("rst.lo", lo, 32'd0);
        checkOutput("rst.busy", busy, 1'b0);
        checkOutput("rst.done", done, 1'b0);
        checkOutput("rst.dbz", div_by_zero, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        runOp("multuMax", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        runOp("multNeg", 2'b00, 32'hFFFFFFFD, 32'd7, 32, 32, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);

`ifdef MULDIV_DIVIDE_EN
        runOp("divNeg", 2'b10, 32'hFFFFFFF9, 32'd2, 32, 32, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        runOp("divOvf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32, 32, 32'h00000000, 32'h80000000, 1'b0);
        runOp("divu", 2'b11, 32'd100, 32'd7, 32, 32, 32'd2, 32'd14, 1'b0);
        runOp("divZero", 2'b11, 32'd100, 32'd0, 1, 1, 32'h00000064, 32'hFFFFFFFF, 1'b1);
        @(negedge clock);
        checkOutput("divZero.dbzHeld", div_by_zero, 1'b1);
`else
        runOp("divNeg", 2'b10, 32'hFFFFFFF9, 32'd2, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        runOp("divOvf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        runOp("divZero", 2'b11, 32'd100, 32'd0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
`endif

        // Reset in the middle of an iteration.
        applyStimulus(2'b01, 32'd3, 32'd5);
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checkOutput("midRst.hi", hi, 32'd0);
        checkOutput("midRst.lo", lo, 32'd0);
        checkOutput("midRst.busy", busy, 1'b0);
        checkOutput("midRst.done", done, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        runOp("afterRst", 2'b01, 32'd3, 32'd5, 32, 32, 32'd0, 32'd15, 1'b0);

        // Start held through MUL, MTHI/MTLO while busy, back-to-back issue from DONE.
        @(negedge clock);
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'd6;
        rt_val = 32'd7;
        @(negedge clock);
        rs_val = 32'd2;
        rt_val = 32'd2;
        hi_we  = 1'b1;
        lo_we  = 1'b1;
        repeat (5) @(negedge clock);
        checkOutput("held.hiMid", hi, 32'd0);
        checkOutput("held.loMid", lo, 32'd15);
        checkOutput("held.busyMid", busy, 1'b1);
        waitDone(lat, bc);
        checkOutput("held.lat", lat, 27);
        checkOutput("held.hi", hi, 32'd0);
        checkOutput("held.lo", lo, 32'd42);
        @(negedge clock);
        checkOutput("b2b.busy", busy, 1'b1);
        checkOutput("b2b.done", done, 1'b0);
        checkOutput("b2b.hiWrite", hi, 32'd2);
        checkOutput("b2b.loWrite", lo, 32'd2);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        waitDone(lat, bc);
        checkOutput("b2b.lat", lat, 32);
        checkOutput("b2b.hi", hi, 32'd0);
        checkOutput("b2b.lo", lo, 32'd4);

        // MTHI in IDLE.
        @(negedge clock);
        hi_we  = 1'b1;
        rs_val = 32'h12345678;
        @(negedge clock);
        hi_we  = 1'b0;
        checkOutput("mthi.hi", hi, 32'h12345678);
        checkOutput("mthi.lo", lo, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
